// File: rtl/led_reg_ctrl.sv
// led_reg_ctrl: decodes I2C frames (address, register pointer, data) into an
// LED register file and feeds read-back bytes to the bus transmit path.
module led_reg_ctrl #(
  parameter logic [6:0]  DEV_ADDR = 7'h2A,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  input  logic                      frame_end,
  input  logic                      tx_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_req,
  output logic                      led_en,
  output logic [(NUM_REGS-1)*8-1:0] duty_flat,
  output logic                      busy
);

  localparam int unsigned PW = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PTR    = 3'd1,
    ST_WRITE  = 3'd2,
    ST_READ   = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_s;
  state_t          state_n_s;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   ptr_s;
  logic            outst_r;
  logic            tx_req_r;
  logic [7:0]      tx_data_r;
  logic            busy_r;
  logic            wr_en_s;
  logic            ptr_ld_s;
  logic            issue_s;
  logic [7:0]      reg_r [NUM_REGS];

  // Pointer advance; NUM_REGS is a power of two so the add wraps naturally.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return p + PW'(1'b1);
  endfunction

  // Register 0 only keeps its enable bit; the rest read back as zero.
  function automatic logic [7:0] wr_mask(input logic [PW-1:0] p, input logic [7:0] d);
    if (p == {PW{1'b0}}) begin
      return {7'b000_0000, d[0]};
    end else begin
      return d;
    end
  endfunction

  // Next-state decode and per-cycle access strobes.
  always_comb begin
    state_s  = state_r;
    wr_en_s  = 1'b0;
    ptr_ld_s = 1'b0;
    issue_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data[7:1] == DEV_ADDR) begin
            if (rx_data[0]) begin
              state_s = ST_READ;
            end else begin
              state_s = ST_PTR;
            end
          end else begin
            state_s = ST_IGNORE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PTR: begin
        if (rx_valid) begin
          ptr_ld_s = 1'b1;
          state_s  = ST_WRITE;
        end else begin
          state_s  = ST_PTR;
        end
      end
      ST_WRITE: begin
        if (rx_valid) begin
          wr_en_s = 1'b1;
        end else begin
          wr_en_s = 1'b0;
        end
      end
      ST_READ: begin
        // A STOP in the same cycle closes the frame; no new request then.
        if (tx_ready && !outst_r && !frame_end) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      ST_IGNORE: begin
        state_s = ST_IGNORE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // STOP returns to IDLE from any state after the current byte is handled.
  assign state_n_s = frame_end ? ST_IDLE : state_s;

  // Pointer next value: load from the pointer byte, else advance per access.
  always_comb begin
    ptr_s = ptr_r;
    if (ptr_ld_s) begin
      ptr_s = rx_data[PW-1:0];
    end else if (wr_en_s || issue_s) begin
      ptr_s = ptr_inc(ptr_r);
    end else begin
      ptr_s = ptr_r;
    end
  end

  // Control state, pointer, transmit handshake and busy flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {PW{1'b0}};
      outst_r   <= 1'b0;
      tx_req_r  <= 1'b0;
      tx_data_r <= 8'h00;
      busy_r    <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      ptr_r    <= ptr_s;
      tx_req_r <= issue_s;
      busy_r   <= (state_r != ST_IDLE);
      if (issue_s) begin
        tx_data_r <= reg_r[ptr_r];
      end
      if (frame_end) begin
        outst_r <= 1'b0;
      end else if (issue_s) begin
        outst_r <= 1'b1;
      end else if (!tx_ready) begin
        outst_r <= 1'b0;
      end
    end
  end

  // Register file write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        reg_r[k] <= 8'h00;
      end
    end else if (wr_en_s) begin
      reg_r[ptr_r] <= wr_mask(ptr_r, rx_data);
    end
  end

  for (genvar k = 1; k < NUM_REGS; k++) begin : g_duty
    assign duty_flat[(k-1)*8 +: 8] = reg_r[k];
  end

  assign led_en  = reg_r[0][0];
  assign tx_data = tx_data_r;
  assign tx_req  = tx_req_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_led_reg_ctrl.sv
// Self-checking bench for led_reg_ctrl against a byte-level register model.
module tb_led_reg_ctrl;

  localparam int NR = 16;
  localparam int DW = (NR - 1) * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          frame_end = 1'b0;
  logic          tx_ready = 1'b0;
  logic [7:0]    tx_data;
  logic          tx_req;
  logic          led_en;
  logic [DW-1:0] duty_flat;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int req_count = 0;

  logic [7:0] m_regs [NR];
  int         m_ptr;

  led_reg_ctrl #(.DEV_ADDR(7'h2A), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_end(frame_end), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_req(tx_req), .led_en(led_en), .duty_flat(duty_flat), .busy(busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Count transmit request cycles.
  always @(negedge clk) if (tx_req === 1'b1) req_count++;

  // Hard bound on total run time.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [DW-1:0] exp_flat();
    logic [DW-1:0] f;
    for (int k = 1; k < NR; k++) f[(k-1)*8 +: 8] = m_regs[k];
    return f;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
    m_ptr = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1; frame_end = fe;
    @(negedge clk);
    rx_data = 8'h00; rx_valid = 1'b0; frame_end = 1'b0;
  endtask

  task automatic end_frame();
    @(negedge clk);
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  // Address + pointer + data bytes + STOP, with the model updated alongside.
  task automatic wr_frame(input logic [7:0] p, input logic [7:0] d[$]);
    send_byte(8'h54, 1'b0);
    send_byte(p, 1'b0);
    m_ptr = int'(p) % NR;
    foreach (d[i]) begin
      send_byte(d[i], 1'b0);
      m_regs[m_ptr] = (m_ptr == 0) ? (d[i] & 8'h01) : d[i];
      m_ptr = (m_ptr + 1) % NR;
    end
    end_frame();
  endtask

  // Read frame of n bytes with tx_ready toggled between requests.
  task automatic rd_frame(input int n);
    int w;
    tx_ready = 1'b0;
    send_byte(8'h55, 1'b0);
    for (int i = 0; i < n; i++) begin
      tx_ready = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (tx_req !== 1'b1 && w < 20);
      checks++;
      if (tx_req !== 1'b1) begin
        failures++;
        $display("FAIL rd_req_timeout got=%b exp=1", tx_req);
      end else begin
        checks++;
        if (tx_data !== m_regs[m_ptr]) begin
          failures++;
          $display("FAIL rd_data ptr=%0d got=%h exp=%h", m_ptr, tx_data, m_regs[m_ptr]);
        end
        m_ptr = (m_ptr + 1) % NR;
      end
      tx_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (tx_req !== 1'b0) begin
        failures++;
        $display("FAIL rd_req_single got=%b exp=0", tx_req);
      end
    end
    end_frame();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_req, busy, led_en, tx_data, duty_flat} !== {3'b000, 8'h00, {DW{1'b0}}}) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b %h %h exp=zeros", tx_req, busy, led_en, tx_data, duty_flat);
    end
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_write_burst();
    logic [7:0] q[$];
    int r0;
    q = {8'h10, 8'h20, 8'h30};
    wr_frame(8'h01, q);
    @(negedge clk);
    checks++;
    if (duty_flat[23:0] !== 24'h30_20_10) begin
      failures++;
      $display("FAIL burst_regs got=%h exp=302010", duty_flat[23:0]);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL burst_busy got=%b exp=0", busy);
    end
    checks++;
    if (m_ptr !== 4 || duty_flat !== exp_flat()) begin
      failures++;
      $display("FAIL burst_flat got=%h exp=%h", duty_flat, exp_flat());
    end
    r0 = req_count;
    rd_frame(1);
    checks++;
    if (tx_data !== 8'h00 || req_count - r0 !== 1) begin
      failures++;
      $display("FAIL burst_ptr4 got=%h/%0d exp=00/1", tx_data, req_count - r0);
    end
  endtask

  task automatic test_wrap_enable();
    logic [7:0] q[$];
    q = {8'hAA, 8'hFF};
    wr_frame(8'h0F, q);
    @(negedge clk);
    checks++;
    if (duty_flat[14*8 +: 8] !== 8'hAA) begin
      failures++;
      $display("FAIL wrap_reg15 got=%h exp=aa", duty_flat[14*8 +: 8]);
    end
    checks++;
    if (led_en !== 1'b1) begin
      failures++;
      $display("FAIL wrap_led_en got=%b exp=1", led_en);
    end
    q.delete();
    wr_frame(8'h00, q);
    rd_frame(1);
    checks++;
    if (tx_data !== 8'h01) begin
      failures++;
      $display("FAIL wrap_reg0_read got=%h exp=01", tx_data);
    end
  endtask

  task automatic test_read_back();
    logic [7:0] q[$];
    int r0;
    q.delete();
    wr_frame(8'h02, q);
    r0 = req_count;
    rd_frame(2);
    repeat (3) @(negedge clk);
    checks++;
    if (req_count - r0 !== 2) begin
      failures++;
      $display("FAIL readback_pulses got=%0d exp=2", req_count - r0);
    end
    checks++;
    if (tx_data !== 8'h30) begin
      failures++;
      $display("FAIL readback_hold got=%h exp=30", tx_data);
    end
  endtask

  task automatic test_read_latency();
    logic [7:0] q[$];
    q.delete();
    wr_frame(8'h01, q);
    tx_ready = 1'b1;
    send_byte(8'h55, 1'b0);
    checks++;
    if (tx_req !== 1'b0) begin
      failures++;
      $display("FAIL lat_early got=%b exp=0", tx_req);
    end
    @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (tx_req !== 1'b1 || tx_data !== 8'h10) begin
      failures++;
      $display("FAIL lat_req got=%b/%h exp=1/10", tx_req, tx_data);
    end
    m_ptr = (m_ptr + 1) % NR;
    @(negedge clk);
    checks++;
    if (tx_req !== 1'b0) begin
      failures++;
      $display("FAIL lat_single got=%b exp=0", tx_req);
    end
    end_frame();
  endtask

  task automatic test_mismatch();
    logic [DW-1:0] snap;
    snap = exp_flat();
    send_byte(8'h56, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h77, 1'b0);
    checks++;
    if (busy !== 1'b1 || duty_flat !== snap) begin
      failures++;
      $display("FAIL mismatch_ignore got=%b/%h exp=1/%h", busy, duty_flat, snap);
    end
    end_frame();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || duty_flat !== snap) begin
      failures++;
      $display("FAIL mismatch_idle got=%b/%h exp=0/%h", busy, duty_flat, snap);
    end
    rd_frame(1);
  endtask

  task automatic test_simultaneous();
    send_byte(8'h54, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h99, 1'b1);
    m_regs[5] = 8'h99;
    m_ptr = 6;
    checks++;
    if (duty_flat[4*8 +: 8] !== 8'h99 || busy !== 1'b1) begin
      failures++;
      $display("FAIL simul_write got=%h/%b exp=99/1", duty_flat[4*8 +: 8], busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL simul_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_midframe_reset();
    logic [7:0] q[$];
    send_byte(8'h54, 1'b0);
    send_byte(8'h07, 1'b0);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({tx_req, busy, led_en, tx_data, duty_flat} !== {3'b000, 8'h00, {DW{1'b0}}}) begin
      failures++;
      $display("FAIL async_reset got=%b%b%b %h %h exp=zeros", tx_req, busy, led_en, tx_data, duty_flat);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b1;
    q = {8'h44};
    wr_frame(8'h03, q);
    @(negedge clk);
    checks++;
    if (duty_flat[2*8 +: 8] !== 8'h44 || duty_flat !== exp_flat()) begin
      failures++;
      $display("FAIL reset_rewrite got=%h exp=%h", duty_flat, exp_flat());
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [6:0] a;
    int kind;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        q.delete();
        for (int i = 0; i < $urandom_range(1, 4); i++) q.push_back(8'($urandom_range(0, 255)));
        wr_frame(8'($urandom_range(0, 255)), q);
      end else if (kind == 1) begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h2A) a = 7'h2B;
        send_byte({a, 1'($urandom_range(0, 1))}, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
        end_frame();
      end else begin
        rd_frame($urandom_range(1, 3));
      end
      @(negedge clk);
      checks++;
      if (duty_flat !== exp_flat() || led_en !== m_regs[0][0] || busy !== 1'b0) begin
        failures++;
        $display("FAIL random_frame%0d got=%h/%b/%b exp=%h/%b/0", f, duty_flat, led_en, busy, exp_flat(), m_regs[0][0]);
      end
    end
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_write_burst();
    test_wrap_enable();
    test_read_back();
    test_read_latency();
    test_mismatch();
    test_simultaneous();
    test_midframe_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_reg_ctrl.md
# led_reg_ctrl

Register controller downstream of `i2c_bus_interface`. Consumes received bytes (`rx_data`/`rx_valid`) plus a STOP pulse, and decodes them as device address, register pointer and data. Drives the LED driver's register file (global enable plus per-channel PWM duty) and supplies read-back bytes to the bus interface's transmit path (`tx_data`/`tx_req`/`tx_ready`).

## Interface
- `DEV_ADDR`, default 7'h2A: 7-bit I2C device address matched against the first byte of each frame.
- `NUM_REGS`, default 16: number of 8-bit registers; power of two, 2..256. `PW = log2(NUM_REGS)`.
- `clk`, input, 1: system clock; all logic on its rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: received byte, valid while `rx_valid` = 1.
- `rx_valid`, input, 1: one-cycle pulse per received byte.
- `frame_end`, input, 1: one-cycle pulse from the bus interface STOP detector.
- `tx_ready`, input, 1: bus interface can accept a transmit byte.
- `tx_data`, output, 8: read-back byte, held stable from `tx_req` until the next request.
- `tx_req`, output, 1: one-cycle transmit request.
- `led_en`, output, 1: register 0 bit 0.
- `duty_flat`, output, `(NUM_REGS-1)*8`: registers 1..NUM_REGS-1 concatenated; reg k sits at bits `[(k-1)*8 +: 8]`.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, PTR, WRITE, READ, IGNORE.
- **IDLE.** On `rx_valid`, compare `rx_data[7:1]` with `DEV_ADDR`.
  - Mismatch -> IGNORE.
  - Match with `rx_data[0]` = 0 -> PTR.
  - Match with `rx_data[0]` = 1 -> READ, using the current `ptr`.
- **PTR.** On `rx_valid`, `ptr <= rx_data[PW-1:0]` (upper bits discarded) -> WRITE.
- **WRITE.** Each `rx_valid` writes `rx_data` to `reg[ptr]`, then `ptr <= ptr+1`, wrapping `NUM_REGS-1` -> 0.
  - Register 0 stores only bit 0; bits 7:1 read as 0.
- **READ.** Issue `tx_req` with `tx_data = reg[ptr]` when `tx_ready` = 1 and no request is outstanding. Then set outstanding and increment `ptr` (with wrap).
  - Outstanding clears when `tx_ready` is sampled 0.
  - `rx_valid` is ignored in READ.
- **IGNORE.** Discard all `rx_valid` until `frame_end`.
- **Frame end.** `frame_end` in any state -> IDLE; `ptr` is retained.
  - `rx_valid` in the same cycle as `frame_end`: the byte is processed in the current state (a write completes), and the next state is IDLE.
  - `frame_end` while a request is outstanding: clear outstanding.
- **Repeated START** without STOP is not decoded; the address byte is recognised only in IDLE.
- **Reset.** `reset` = 0 at any time, mid-frame included, clears all of the following immediately:
  - all registers, `ptr`, the outstanding flag and `tx_data` to 0;
  - state to IDLE;
  - `tx_req`, `led_en`, `duty_flat` and `busy` to 0.

## Timing
- All outputs are registered.
- Write latency: `rx_valid` sampled at edge N -> `duty_flat`/`led_en` updated after edge N (visible in cycle N+1).
- State change occurs on the same edge that samples `rx_valid` or `frame_end`; `busy` follows one edge later.
- Read latency:
  - Entering READ at edge N with `tx_ready` = 1 -> `tx_req` high for exactly the cycle after edge N+1.
  - `tx_data` is valid in that same cycle.
- `tx_req` is never high on two consecutive cycles. The minimum spacing between requests is `tx_ready` low for ≥1 cycle, then high.
- Pointer increment for both read and write takes effect on the same edge as the access.

## Test plan
- **Write burst.**
  - Stimulus: reset release, bytes 0x54 (addr 0x2A, W), 0x01, 0x10, 0x20, 0x30, `frame_end`.
  - Required: reg1 = 0x10, reg2 = 0x20, reg3 = 0x30 in `duty_flat`; `busy` returns to 0; `ptr` = 4.
- **Wrap and enable.**
  - Stimulus: 0x54, 0x0F, 0xAA, 0xFF, `frame_end`.
  - Required: reg15 = 0xAA; reg0 reads 0x01; `led_en` = 1.
- **Read-back.**
  - Stimulus: after the write burst, 0x54, 0x02, `frame_end`, then 0x55 with `tx_ready` toggling high/low for 2 bytes.
  - Required: `tx_data` = 0x20, then 0x30; exactly 2 `tx_req` pulses.
- **Address mismatch.**
  - Stimulus: 0x56, 0x01, 0x77, `frame_end`.
  - Required: no register changes; state IGNORE until `frame_end`; then IDLE.
- **Simultaneous events.**
  - Stimulus: `rx_valid` with 0x99 coincident with `frame_end` in WRITE at `ptr` = 5.
  - Required: reg5 = 0x99; state IDLE next cycle.
- **Mid-frame reset.**
  - Stimulus: assert `reset` = 0 after the pointer byte.
  - Required: all outputs 0 asynchronously. A following 0x54, 0x03, 0x44 writes reg3 = 0x44 normally.
